// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, D requester and RAM port signals around mem_port_arbiter.
// The arbiter uses the slave view; the CPU/RAM environment uses the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [INST_W-1:0] if_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [2:0]        d_wid_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_misalign_o;

  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [2:0]        ram_wid_o;
  logic [DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wid_i, ram_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o, d_misalign_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wid_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wid_i, ram_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o, d_misalign_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wid_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and load/store. Data wins unless
// IF has been starved STARVE_LIMIT times in a row; read data is routed back one cycle later.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned INST_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {StNormal, StForceIf} state_e;
  typedef enum logic [1:0] {RespNone, RespIf, RespD} resp_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  resp_e           resp_q, resp_d;
  logic            addr2_q, addr2_d;
  logic            mis_q, mis_d;

  logic [2:0]      align_mask;
  logic            mis, d_ok, if_win, d_win;
  logic [CntW-1:0] cnt_inc;
  logic            starve_hit;

  always_comb begin
    unique case (bus.d_wid_i[1:0])
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign mis  = bus.d_req_i & (|(bus.d_addr_i[2:0] & align_mask));
  assign d_ok = bus.d_req_i & ~mis;

  always_comb begin
    if_win = 1'b0;
    unique case (state_q)
      StNormal:  if_win = bus.if_req_i & ~d_ok;
      StForceIf: if_win = bus.if_req_i;
      default:   if_win = 1'b0;
    endcase
  end

  assign d_win = d_ok & ~if_win;

  // A misaligned access is consumed without touching the RAM, so IF may share the cycle.
  assign bus.if_gnt_o    = if_win;
  assign bus.d_gnt_o     = d_win | mis;
  assign bus.ram_en_o    = if_win | d_win;
  assign bus.ram_we_o    = d_win & bus.d_we_i;
  assign bus.ram_addr_o  = if_win ? bus.if_addr_i : (d_win ? bus.d_addr_i : '0);
  assign bus.ram_wdata_o = d_win ? bus.d_wdata_i : '0;
  assign bus.ram_wid_o   = if_win ? 3'b010 : (d_win ? bus.d_wid_i : 3'b000);

  assign cnt_inc    = cnt_q + 1'b1;
  assign starve_hit = (STARVE_LIMIT != 0) && (cnt_inc == CntW'(STARVE_LIMIT));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (if_win || !bus.if_req_i) begin
      state_d = StNormal;
    end else if (starve_hit) begin
      state_d = StForceIf;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  always_comb begin
    resp_d  = RespNone;
    addr2_d = 1'b0;
    mis_d   = mis;
    if (if_win) begin
      resp_d  = RespIf;
      addr2_d = bus.if_addr_i[2];
    end else if (d_win && !bus.d_we_i) begin
      resp_d = RespD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StNormal;
      cnt_q   <= '0;
      resp_q  <= RespNone;
      addr2_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      addr2_q <= addr2_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.if_rvalid_o  = (resp_q == RespIf);
  assign bus.d_rvalid_o   = (resp_q == RespD);
  assign bus.d_misalign_o = mis_q;
  assign bus.if_rdata_o   = !bus.if_rvalid_o ? '0 :
                            (addr2_q ? bus.ram_rdata_i[2*INST_W-1:INST_W]
                                     : bus.ram_rdata_i[INST_W-1:0]);
  assign bus.d_rdata_o    = bus.d_rvalid_o ? bus.ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter, checked against a transaction-level
// model of the grant/starvation rules and a bench-side RAM.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64), .INST_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .INST_W(32), .STARVE_LIMIT(STARVE)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench RAM: written words are remembered, untouched words follow a fixed hash.
  logic [63:0] mem [logic [63:0]];

  // Reference model state.
  int          starve;
  bit          forced;
  int          resp_kind;   // 0 none, 1 IF, 2 D
  logic [63:0] resp_word;
  bit          resp_addr2;
  bit          mis_exp;
  bit          last_if_win;
  bit          last_d_done;
  int          spot_if;
  int          spot_d;

  function automatic logic [63:0] rd(input logic [63:0] a);
    logic [63:0] idx;
    idx = a >> 3;
    if (mem.exists(idx)) return mem[idx];
    return (idx * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    starve    = 0;
    forced    = 0;
    resp_kind = 0;
    resp_word = '0;
    resp_addr2 = 0;
    mis_exp   = 0;
  endtask

  // Called at posedge+1 with this cycle's inputs already applied; returns at next posedge+1.
  task automatic run_cycle();
    bit          mis, d_ok, if_win, d_win, hit, nmis, naddr2;
    int          nkind;
    logic [63:0] exp_word, nxt_ram;
    #3;
    mis    = bus.d_req_i && ((bus.d_addr_i % (64'd1 << bus.d_wid_i[1:0])) != 0);
    d_ok   = bus.d_req_i && !mis;
    if_win = bus.if_req_i && (forced || !d_ok);
    d_win  = d_ok && !if_win;

    check("if_gnt", bus.if_gnt_o, if_win);
    check("d_gnt", bus.d_gnt_o, d_win || mis);
    check("ram_en", bus.ram_en_o, if_win || d_win);
    if (if_win || d_win) begin
      check("ram_addr", bus.ram_addr_o, if_win ? bus.if_addr_i : bus.d_addr_i);
      check("ram_we", bus.ram_we_o, d_win && bus.d_we_i);
      check("ram_wid", bus.ram_wid_o, if_win ? 64'd2 : 64'(bus.d_wid_i));
      if (d_win && bus.d_we_i) check("ram_wdata", bus.ram_wdata_o, bus.d_wdata_i);
    end
    check("if_rvalid", bus.if_rvalid_o, resp_kind == 1);
    check("d_rvalid", bus.d_rvalid_o, resp_kind == 2);
    if (resp_kind == 1)
      check("if_rdata", bus.if_rdata_o, resp_addr2 ? resp_word[63:32] : resp_word[31:0]);
    if (resp_kind == 2) check("d_rdata", bus.d_rdata_o, resp_word);
    check("d_misalign", bus.d_misalign_o, mis_exp);
    if (spot_if >= 0) check("spot_if_gnt", bus.if_gnt_o, spot_if[0]);
    if (spot_d >= 0) check("spot_d_gnt", bus.d_gnt_o, spot_d[0]);

    nkind    = 0;
    exp_word = '0;
    naddr2   = 0;
    if (if_win) begin
      nkind    = 1;
      exp_word = rd(bus.if_addr_i);
      naddr2   = bus.if_addr_i[2];
    end else if (d_win && !bus.d_we_i) begin
      nkind    = 2;
      exp_word = rd(bus.d_addr_i);
    end

    // The bench RAM answers whatever the DUT actually puts on the port.
    nxt_ram = {$urandom, $urandom};
    if (bus.ram_en_o && !bus.ram_we_o) nxt_ram = rd(bus.ram_addr_o);
    if (bus.ram_en_o && bus.ram_we_o) mem[bus.ram_addr_o >> 3] = bus.ram_wdata_o;

    hit = 0;
    if (bus.if_req_i && !if_win) begin
      starve++;
      if (starve == STARVE) begin
        hit    = 1;
        starve = 0;
      end
    end else begin
      starve = 0;
    end
    if (if_win || !bus.if_req_i) forced = 0;
    if (hit) forced = 1;
    last_if_win = if_win;
    last_d_done = d_win || mis;
    nmis        = mis;

    @(posedge clk);
    #1;
    bus.ram_rdata_i = nxt_ram;
    resp_kind       = nkind;
    resp_word       = exp_word;
    resp_addr2      = naddr2;
    mis_exp         = nmis;
  endtask

  task automatic set_if(input bit req, input logic [63:0] addr);
    bus.if_req_i  = req;
    bus.if_addr_i = addr;
  endtask

  task automatic set_d(input bit req, input bit we, input logic [63:0] addr, input logic [2:0] wid,
                       input logic [63:0] wdata);
    bus.d_req_i   = req;
    bus.d_we_i    = we;
    bus.d_addr_i  = addr;
    bus.d_wid_i   = wid;
    bus.d_wdata_i = wdata;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    spot_if  = -1;
    spot_d   = -1;
    model_reset();
    rst_n = 1'b0;
    set_if(0, '0);
    set_d(0, 0, '0, 3'd0, '0);
    bus.ram_rdata_i = '0;

    #2;
    check("rst_if_rvalid", bus.if_rvalid_o, 0);
    check("rst_d_rvalid", bus.d_rvalid_o, 0);
    check("rst_misalign", bus.d_misalign_o, 0);
    check("rst_ram_en", bus.ram_en_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lone IF read of the upper half.
    mem[64'h1004 >> 3] = 64'hAAAA_BBBB_CCCC_DDDD;
    set_if(1, 64'h1004);
    spot_if = 1;
    run_cycle();
    spot_if = -1;
    set_if(0, '0);
    run_cycle();

    // IF and D load held together: D x4, forced IF, then D again.
    set_if(1, 64'h40);
    set_d(1, 0, 64'h80, 3'd3, '0);
    for (int i = 0; i < 6; i++) begin
      spot_if = (i == 4) ? 1 : 0;
      spot_d  = (i == 4) ? 0 : 1;
      run_cycle();
    end
    spot_if = -1;
    spot_d  = -1;
    set_if(0, '0);
    set_d(0, 0, '0, 3'd0, '0);
    run_cycle();

    // Doubleword store, then read it back.
    set_d(1, 1, 64'h2000, 3'd3, 64'h1122_3344_5566_7788);
    run_cycle();
    set_d(1, 0, 64'h2000, 3'd3, '0);
    run_cycle();
    set_d(0, 0, '0, 3'd0, '0);
    run_cycle();

    // Misaligned word load alongside an IF fetch.
    set_if(1, 64'h3000);
    set_d(1, 0, 64'h2003, 3'd2, '0);
    spot_if = 1;
    spot_d  = 1;
    run_cycle();
    spot_if = -1;
    spot_d  = -1;
    set_if(0, '0);
    set_d(0, 0, '0, 3'd0, '0);
    run_cycle();

    // Back-to-back loads.
    set_d(1, 0, 64'h100, 3'd3, '0);
    run_cycle();
    set_d(1, 0, 64'h108, 3'd3, '0);
    run_cycle();
    set_d(0, 0, '0, 3'd0, '0);
    run_cycle();
    run_cycle();

    // Reset while an IF read is in flight.
    set_if(1, 64'h1000);
    run_cycle();
    set_if(0, '0);
    rst_n = 1'b0;
    #1;
    check("midrst_if_rvalid", bus.if_rvalid_o, 0);
    check("midrst_if_rdata", bus.if_rdata_o, 0);
    check("midrst_d_rvalid", bus.d_rvalid_o, 0);
    check("midrst_misalign", bus.d_misalign_o, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    run_cycle();

    // Random traffic; each requester holds its request until it is consumed.
    last_if_win = 1;
    last_d_done = 1;
    for (int c = 0; c < 500; c++) begin
      if (!bus.if_req_i || last_if_win)
        set_if($urandom_range(0, 3) != 0, 64'($urandom_range(0, 255)) << 2);
      if (!bus.d_req_i || last_d_done) begin
        logic [63:0] a;
        logic [2:0]  w;
        a = 64'($urandom_range(0, 1023));
        w = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << w[1:0]) - 64'd1);
        set_d($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, w, {$urandom, $urandom});
      end
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
